// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the single-byte I2C master:
//   state_t   - transfer FSM states
//   quarter_t - quarter index within one SCL bit cell
//   BIT_CNT_W - width of the per-byte bit counter
//   ACK/NACK  - SDA levels of the acknowledge bit
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam int   BIT_CNT_W = 3;
  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MNACK, STOP
  } state_t;

  // Q0/Q1: SCL low (SDA may change), Q2/Q3: SCL high (SDA stable)
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

  // States that occupy a full 9-per-byte bit cell (START/STOP are framing)
  function automatic logic is_bit_state(input state_t s);
    return (s inside {ADDR, AACK, WDATA, WACK, RDATA, MNACK});
  endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// -----------------------------------------------------------------------------
// i2c_clk_gen
// Quarter-period divider for the I2C master. Counts QDIV system clocks per
// quarter and steps the quarter index Q0..Q3 while run is high; held at
// zero otherwise.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   run          - divider enable (master busy)
//   restart      - at the next tick, jump to Q0 instead of advancing
//   bit_en       - current state is a data/ack bit cell
//   q            - current quarter
//   tick         - last clk of any quarter
//   samp_tick    - last clk of Q2 (SDA sample point, Q2->Q3 boundary)
//   cell_tick    - last clk of Q3 (end of bit cell)
//   scl_lvl      - SCL level implied by the quarter
//   sample_l     - high during Q2..Q3 of bit cells only
// -----------------------------------------------------------------------------
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int QDIV = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     run,
  input  logic     restart,
  input  logic     bit_en,
  output quarter_t q,
  output logic     tick,
  output logic     samp_tick,
  output logic     cell_tick,
  output logic     scl_lvl,
  output logic     sample_l
);

  localparam int            CW   = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
      q   <= Q0;
    end else if (tick) begin
      cnt <= '0;
      q   <= restart ? Q0 : quarter_t'(q + 2'd1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick      = run && (cnt == LAST);
  assign samp_tick = tick && (q == Q2);
  assign cell_tick = tick && (q == Q3);
  assign scl_lvl   = (q == Q2) || (q == Q3);
  assign sample_l  = bit_en && scl_lvl;

endmodule

// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master
// Single-byte I2C master: START, {addr,rw}, address ACK check, one data byte
// written or read, STOP. SCL period is 4*QDIV system clocks.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   addr,rw     - slave address and direction, captured on start
//   data_w      - write byte, captured on start
//   start       - transfer request, accepted only while busy=0
//   data_out    - byte read from the slave; valid_out pulses when updated
//   scl         - I2C clock (idles high)
//   sda         - I2C data, open-drain (drives 0 or Z)
//   t_sda       - slave-side SDA level used for sampling when I2C_TSDA_EN
//   busy        - high from start acceptance until STOP completes
//   erro_addr   - sticky address-NACK flag of the last transfer
// Build option:
//   I2C_TSDA_EN - defined: sample from t_sda; undefined: sample the sda pin
//                 (pull-up assumed), t_sda left unused.
// -----------------------------------------------------------------------------
module i2c_master
  import i2c_pkg::*;
#(
  parameter int QDIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_w,
  input  logic       start,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       scl,
  inout  wire        sda,
  input  logic       t_sda,
  output logic       busy,
  output logic       erro_addr
);

  state_t                 state, state_nxt;
  quarter_t               q;
  logic                   tick, samp_tick, cell_tick, scl_lvl, sample_l;
  logic                   restart, bit_en, sda_low, sda_in;
  logic                   rw_r, nack_r;
  logic [7:0]             data_r, sh;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   last_bit;

  i2c_clk_gen #(.QDIV(QDIV)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (busy),
    .restart   (restart),
    .bit_en    (bit_en),
    .q         (q),
    .tick      (tick),
    .samp_tick (samp_tick),
    .cell_tick (cell_tick),
    .scl_lvl   (scl_lvl),
    .sample_l  (sample_l)
  );

  // START is a half cell (two SCL-high quarters); the first address bit
  // then begins at Q0 with SCL falling.
  assign restart  = (state == START) && tick && (q == Q1);
  assign last_bit = (bit_cnt == '0);

`ifdef I2C_TSDA_EN
  assign sda_in = t_sda;
`else
  assign sda_in = sda;
  logic unused_t_sda;
  assign unused_t_sda = t_sda;
`endif

  assign sda = sda_low ? 1'b0 : 1'bz;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:  if (start)                 state_nxt = START;
      START: if (restart)               state_nxt = ADDR;
      ADDR:  if (cell_tick && last_bit) state_nxt = AACK;
      AACK:  if (cell_tick)             state_nxt = nack_r ? STOP : (rw_r ? RDATA : WDATA);
      WDATA: if (cell_tick && last_bit) state_nxt = WACK;
      WACK:  if (cell_tick)             state_nxt = STOP;
      RDATA: if (cell_tick && last_bit) state_nxt = MNACK;
      MNACK: if (cell_tick)             state_nxt = STOP;
      STOP:  if (cell_tick)             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Pin-level outputs
  always_comb begin
    scl     = scl_lvl;
    sda_low = 1'b0;
    busy    = 1'b1;
    bit_en  = is_bit_state(state);
    unique case (state)
      IDLE: begin
        scl  = 1'b1;
        busy = 1'b0;
      end
      START: begin
        scl     = 1'b1;
        sda_low = 1'b1;
      end
      ADDR, WDATA: sda_low = ~sh[7];
      // Hold SDA low through the SCL rise, release in Q3 for the STOP edge
      STOP:        sda_low = (q != Q3);
      default:     sda_low = 1'b0;
    endcase
  end

  // Datapath: shift register, bit counter, ack capture, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_r      <= 1'b0;
      data_r    <= '0;
      sh        <= '0;
      bit_cnt   <= '0;
      nack_r    <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      erro_addr <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          rw_r      <= rw;
          data_r    <= data_w;
          sh        <= {addr, rw};
          erro_addr <= 1'b0;
        end
        START: if (restart) bit_cnt <= '1;
        ADDR, WDATA: if (cell_tick) begin
          sh      <= {sh[6:0], 1'b0};
          bit_cnt <= bit_cnt - BIT_CNT_W'(1);
        end
        AACK: begin
          // Only a clean 1 is a NACK; 0, X or Z fall to the else branch
          if (samp_tick) begin
            if (sda_in == NACK) nack_r <= 1'b1;
            else                nack_r <= 1'b0;
          end
          if (cell_tick) begin
            if (nack_r) erro_addr <= 1'b1;
            sh      <= data_r;
            bit_cnt <= '1;
          end
        end
        RDATA: begin
          if (samp_tick) sh      <= {sh[6:0], sda_in};
          if (cell_tick) bit_cnt <= bit_cnt - BIT_CNT_W'(1);
        end
        MNACK: if (cell_tick) begin
          data_out  <= sh;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_master
// Directed bench for i2c_master (QDIV=4). A behavioural slave pulls SDA low
// per bit cell; expected SDA levels at each SCL rise and expected read bytes
// are queued when a transfer is set up and popped as the bus runs.
// -----------------------------------------------------------------------------
module tb_i2c_master;

  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] data_w = '0;
  logic       start = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       scl;
  wire        sda;
  logic       t_sda;
  logic       busy;
  logic       erro_addr;
  logic       slave_low = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  logic       exp_q[$];
  logic       drv_q[$];
  logic [7:0] exp_data[$];
  logic [7:0] got_q[$];
  int         v_cnt = 0;
  int         f_cnt = 0;
  logic       sl_prev = 1'b0;

  pullup (sda);
  assign sda   = slave_low ? 1'b0 : 1'bz;
  assign t_sda = ~slave_low;

  always #5 clk = ~clk;

  i2c_master #(.QDIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .rw        (rw),
    .data_w    (data_w),
    .start     (start),
    .data_out  (data_out),
    .valid_out (valid_out),
    .scl       (scl),
    .sda       (sda),
    .t_sda     (t_sda),
    .busy      (busy),
    .erro_addr (erro_addr)
  );

  // Output monitors: read results and sample_l falling edges
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      got_q.push_back(data_out);
      v_cnt <= v_cnt + 1;
    end
    if (sl_prev && !dut.sample_l) f_cnt <= f_cnt + 1;
    sl_prev <= dut.sample_l;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic probe(input int sel);
    case (sel)
      0:       return scl;
      1:       return sda;
      default: return busy;
    endcase
  endfunction

  // Bounded wait for a signal (0=scl, 1=sda, 2=busy) to reach lvl
  task automatic wait_lvl(input int sel, input logic lvl, input string tag);
    int n = 0;
    while (probe(sel) !== lvl && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, probe(sel) === lvl}, 32'd1);
  endtask

  task automatic start_xfer(input logic [6:0] a, input logic r, input logic [7:0] d);
    @(negedge clk);
    addr = a; rw = r; data_w = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise",  {31'd0, busy}, 32'd1);
    check("start_scl",  {31'd0, scl},  32'd1);
    check("start_sda",  {31'd0, sda},  32'd0);
  endtask

  task automatic xfer(input logic [6:0] a, input logic r, input logic [7:0] d,
                      input logic ack, input logic [7:0] rbyte, input logic poke);
    logic [7:0] ab;
    int ncells, f0, v0;
    ab = {a, r};
    for (int i = 0; i < 8; i++) begin exp_q.push_back(ab[7-i]); drv_q.push_back(1'b0); end
    exp_q.push_back(!ack); drv_q.push_back(ack);
    if (ack && !r) begin
      for (int i = 0; i < 8; i++) begin exp_q.push_back(d[7-i]); drv_q.push_back(1'b0); end
      exp_q.push_back(1'b0); drv_q.push_back(1'b1);
    end else if (ack && r) begin
      for (int i = 0; i < 8; i++) begin exp_q.push_back(rbyte[7-i]); drv_q.push_back(!rbyte[7-i]); end
      exp_q.push_back(1'b1); drv_q.push_back(1'b0);
      exp_data.push_back(rbyte);
    end
    ncells = exp_q.size();
    f0 = f_cnt;
    v0 = v_cnt;
    start_xfer(a, r, d);
    for (int i = 0; i < ncells; i++) begin
      wait_lvl(0, 1'b0, "cell_scl_fall");
      slave_low = drv_q.pop_front();
      if (poke && i == 4) begin
        addr = 7'h7F; data_w = 8'hFF; rw = ~r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_lvl(0, 1'b1, "cell_scl_rise");
      check($sformatf("sda_bit%0d", i), {31'd0, sda}, {31'd0, exp_q.pop_front()});
    end
    wait_lvl(0, 1'b0, "stop_scl_fall");
    slave_low = 1'b0;
    #1;
    check("stop_sda_low", {31'd0, sda}, 32'd0);
    wait_lvl(0, 1'b1, "stop_scl_rise");
    check("stop_sda_held", {31'd0, sda}, 32'd0);
    wait_lvl(1, 1'b1, "stop_sda_rise");
    check("stop_edge_scl", {31'd0, scl}, 32'd1);
    wait_lvl(2, 1'b0, "busy_fall");
    check("idle_scl", {31'd0, scl}, 32'd1);
    check("idle_sda", {31'd0, sda}, 32'd1);
    check("erro_addr", {31'd0, erro_addr}, {31'd0, !ack});
    check("sample_l_falls", f_cnt - f0, ncells);
    check("valid_pulses", v_cnt - v0, (ack && r) ? 1 : 0);
    while (exp_data.size() > 0) begin
      check("rd_present", got_q.size(), 1);
      if (got_q.size() > 0) check("rd_data", got_q.pop_front(), exp_data.pop_front());
      else void'(exp_data.pop_front());
    end
    repeat (8) @(negedge clk);
    check("no_retrigger", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_scl",   {31'd0, scl},       32'd1);
    check("rst_sda",   {31'd0, sda},       32'd1);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_erro",  {31'd0, erro_addr}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_dout",  {24'd0, data_out},  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    xfer(7'h10, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);   // write, acked
    xfer(7'h59, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b0);   // read 0xA5
    check("dout_a5", {24'd0, data_out}, 32'hA5);
    xfer(7'h22, 1'b0, 8'h33, 1'b0, 8'h00, 1'b0);   // address NACK
    check("dout_kept", {24'd0, data_out}, 32'hA5);
    xfer(7'h6B, 1'b0, 8'hC3, 1'b1, 8'h00, 1'b1);   // start poked while busy
    xfer(7'h7E, 1'b1, 8'h00, 1'b1, 8'h3C, 1'b0);   // second read

    // Reset in the middle of the address phase
    start_xfer(7'h3C, 1'b0, 8'h11);
    repeat (3) begin
      wait_lvl(0, 1'b0, "abort_scl_fall");
      wait_lvl(0, 1'b1, "abort_scl_rise");
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_scl",  {31'd0, scl},  32'd1);
    check("abort_sda",  {31'd0, sda},  32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    xfer(7'h2A, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b0);   // normal write after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
